// File: rtl/sdram_addr_pkg.sv
// -----------------------------------------------------------------------------
// sdram_addr_pkg
// Shared constants for the SDRAM address ring controller slice.
//   ORDER_ROW_FIRST / ORDER_COL_FIRST : field-order selectors for the decoder
//   SDRAM_BA_W / SDRAM_ROW_W / SDRAM_COL_W : widths of the board SDRAM part
// -----------------------------------------------------------------------------
package sdram_addr_pkg;

  // Field order: which address field occupies the least-significant bits.
  localparam int ORDER_ROW_FIRST = 0;  // legacy layout: row, then column, then bank
  localparam int ORDER_COL_FIRST = 1;  // column, then row, then bank

  // Default geometry of the board SDRAM part.
  localparam int SDRAM_BA_W  = 2;
  localparam int SDRAM_ROW_W = 13;
  localparam int SDRAM_COL_W = 9;

endpackage : sdram_addr_pkg

// File: rtl/sdram_addr_decode.sv
// -----------------------------------------------------------------------------
// sdram_addr_decode
// Purely combinational mapper from a flat linear address to SDRAM
// {bank, row, column} fields. The bank always takes the top BA_W bits; ORDER
// chooses whether row or column counts fastest.
// Ports:
//   addr : in  ADDR_W  linear address (lap bit already stripped)
//   ba   : out BA_W    bank field
//   row  : out ROW_W   row field
//   col  : out COL_W   column field
// -----------------------------------------------------------------------------
module sdram_addr_decode
  import sdram_addr_pkg::*;
#(
  parameter int BA_W  = SDRAM_BA_W,
  parameter int ROW_W = SDRAM_ROW_W,
  parameter int COL_W = SDRAM_COL_W,
  parameter int ORDER = ORDER_ROW_FIRST,
  localparam int ADDR_W = BA_W + ROW_W + COL_W
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [BA_W-1:0]   ba,
  output logic [ROW_W-1:0]  row,
  output logic [COL_W-1:0]  col
);

  assign ba = addr[ADDR_W-1 -: BA_W];

  generate
    if (ORDER == ORDER_COL_FIRST) begin : g_col_first
      assign col = addr[COL_W-1:0];
      assign row = addr[COL_W +: ROW_W];
    end else begin : g_row_first
      assign row = addr[ROW_W-1:0];
      assign col = addr[ROW_W +: COL_W];
    end
  endgenerate

endmodule : sdram_addr_decode

// File: rtl/sdram_addr_ring_ctrl.sv
// -----------------------------------------------------------------------------
// sdram_addr_ring_ctrl
// Write/read pointer pair that runs the whole SDRAM as one circular buffer.
// Each pointer carries an extra lap bit so that full and empty are
// distinguishable; occupancy is simply wp - rp.
// Optional watermark output enabled by macro SDRAM_ADDR_RING_WATERMARK_EN.
// Ports:
//   CLK, RESET (async, active-low), CLEAR (sync clear)
//   WR_NEXT / RD_NEXT        : advance pulses (level-sampled every cycle)
//   BA/ROW/COL_WRITE_OUT     : decoded write address
//   BA/ROW/COL_READ_OUT      : decoded read address
//   COUNT, FULL, EMPTY       : occupancy status
//   OVF, UDF                 : sticky overflow / underflow flags
//   WM_LEVEL, ALMOST_FULL    : watermark threshold / registered flag (macro only)
// -----------------------------------------------------------------------------
module sdram_addr_ring_ctrl
  import sdram_addr_pkg::*;
#(
  parameter int BA_W  = SDRAM_BA_W,
  parameter int ROW_W = SDRAM_ROW_W,
  parameter int COL_W = SDRAM_COL_W,
  parameter int ORDER = ORDER_ROW_FIRST,
  localparam int ADDR_W = BA_W + ROW_W + COL_W
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              CLEAR,
  input  logic              WR_NEXT,
  input  logic              RD_NEXT,
  output logic [BA_W-1:0]   BA_WRITE_OUT,
  output logic [ROW_W-1:0]  ROW_WRITE_OUT,
  output logic [COL_W-1:0]  COL_WRITE_OUT,
  output logic [BA_W-1:0]   BA_READ_OUT,
  output logic [ROW_W-1:0]  ROW_READ_OUT,
  output logic [COL_W-1:0]  COL_READ_OUT,
  output logic [ADDR_W:0]   COUNT,
  output logic              FULL,
  output logic              EMPTY,
  output logic              OVF,
  output logic              UDF
`ifdef SDRAM_ADDR_RING_WATERMARK_EN
  ,
  input  logic [ADDR_W:0]   WM_LEVEL,
  output logic              ALMOST_FULL
`endif
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  logic [ADDR_W:0] wp;
  logic [ADDR_W:0] rp;
  logic [ADDR_W:0] wp_nxt;
  logic [ADDR_W:0] rp_nxt;
  logic            wr_acc;
  logic            rd_acc;

  // Status from the pointer registers; modular subtraction handles the lap bit.
  assign COUNT = wp - rp;
  assign FULL  = (COUNT == DEPTH);
  assign EMPTY = (COUNT == '0);

  // A read in the same cycle frees a slot, so a write may proceed while full.
  assign rd_acc = RD_NEXT && !EMPTY;
  assign wr_acc = WR_NEXT && (!FULL || rd_acc);

  always_comb begin
    wp_nxt = wp + {{ADDR_W{1'b0}}, wr_acc};
    rp_nxt = rp + {{ADDR_W{1'b0}}, rd_acc};
    if (CLEAR) begin
      wp_nxt = '0;
      rp_nxt = '0;
    end
  end

  // ---- pointer / flag register stage ----
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wp  <= '0;
      rp  <= '0;
      OVF <= 1'b0;
      UDF <= 1'b0;
    end else begin
      wp <= wp_nxt;
      rp <= rp_nxt;
      if (CLEAR) begin
        OVF <= 1'b0;
        UDF <= 1'b0;
      end else begin
        if (WR_NEXT && !wr_acc) OVF <= 1'b1;
        if (RD_NEXT && EMPTY)   UDF <= 1'b1;
      end
    end
  end

`ifdef SDRAM_ADDR_RING_WATERMARK_EN
  logic [ADDR_W:0] count_nxt;
  assign count_nxt = wp_nxt - rp_nxt;

  // Registered so the flag lines up with the COUNT produced by the same edge.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      ALMOST_FULL <= 1'b0;
    end else if (CLEAR) begin
      ALMOST_FULL <= 1'b0;
    end else begin
      ALMOST_FULL <= (count_nxt >= WM_LEVEL);
    end
  end
`endif

  // ---- combinational address decode ----
  sdram_addr_decode #(
    .BA_W  (BA_W),
    .ROW_W (ROW_W),
    .COL_W (COL_W),
    .ORDER (ORDER)
  ) u_wr_decode (
    .addr (wp[ADDR_W-1:0]),
    .ba   (BA_WRITE_OUT),
    .row  (ROW_WRITE_OUT),
    .col  (COL_WRITE_OUT)
  );

  sdram_addr_decode #(
    .BA_W  (BA_W),
    .ROW_W (ROW_W),
    .COL_W (COL_W),
    .ORDER (ORDER)
  ) u_rd_decode (
    .addr (rp[ADDR_W-1:0]),
    .ba   (BA_READ_OUT),
    .row  (ROW_READ_OUT),
    .col  (COL_READ_OUT)
  );

endmodule : sdram_addr_ring_ctrl

// File: tb/tb_sdram_addr_ring_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sdram_addr_ring_ctrl
// Directed bench for sdram_addr_ring_ctrl with BA_W=1, ROW_W=2, COL_W=1
// (DEPTH=16). dut0 uses ORDER=0, dut1 uses ORDER=1; both share stimulus.
// Packed address values below are {bank,row,col}.
// -----------------------------------------------------------------------------
module tb_sdram_addr_ring_ctrl;

  localparam int BA_W   = 1;
  localparam int ROW_W  = 2;
  localparam int COL_W  = 1;
  localparam int ADDR_W = BA_W + ROW_W + COL_W;

  logic CLK = 1'b0;
  logic RESET;
  logic CLEAR;
  logic WR_NEXT;
  logic RD_NEXT;

  logic [BA_W-1:0]  ba_w0, ba_r0, ba_w1, ba_r1;
  logic [ROW_W-1:0] row_w0, row_r0, row_w1, row_r1;
  logic [COL_W-1:0] col_w0, col_r0, col_w1, col_r1;
  logic [ADDR_W:0]  count0, count1;
  logic full0, empty0, ovf0, udf0;
  logic full1, empty1, ovf1, udf1;
`ifdef SDRAM_ADDR_RING_WATERMARK_EN
  logic [ADDR_W:0] WM_LEVEL;
  logic af0, af1;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  sdram_addr_ring_ctrl #(.BA_W(BA_W), .ROW_W(ROW_W), .COL_W(COL_W), .ORDER(0)) dut0 (
    .CLK           (CLK),
    .RESET         (RESET),
    .CLEAR         (CLEAR),
    .WR_NEXT       (WR_NEXT),
    .RD_NEXT       (RD_NEXT),
    .BA_WRITE_OUT  (ba_w0),
    .ROW_WRITE_OUT (row_w0),
    .COL_WRITE_OUT (col_w0),
    .BA_READ_OUT   (ba_r0),
    .ROW_READ_OUT  (row_r0),
    .COL_READ_OUT  (col_r0),
    .COUNT         (count0),
    .FULL          (full0),
    .EMPTY         (empty0),
    .OVF           (ovf0),
    .UDF           (udf0)
`ifdef SDRAM_ADDR_RING_WATERMARK_EN
    ,
    .WM_LEVEL      (WM_LEVEL),
    .ALMOST_FULL   (af0)
`endif
  );

  sdram_addr_ring_ctrl #(.BA_W(BA_W), .ROW_W(ROW_W), .COL_W(COL_W), .ORDER(1)) dut1 (
    .CLK           (CLK),
    .RESET         (RESET),
    .CLEAR         (CLEAR),
    .WR_NEXT       (WR_NEXT),
    .RD_NEXT       (RD_NEXT),
    .BA_WRITE_OUT  (ba_w1),
    .ROW_WRITE_OUT (row_w1),
    .COL_WRITE_OUT (col_w1),
    .BA_READ_OUT   (ba_r1),
    .ROW_READ_OUT  (row_r1),
    .COL_READ_OUT  (col_r1),
    .COUNT         (count1),
    .FULL          (full1),
    .EMPTY         (empty1),
    .OVF           (ovf1),
    .UDF           (udf1)
`ifdef SDRAM_ADDR_RING_WATERMARK_EN
    ,
    .WM_LEVEL      (WM_LEVEL),
    .ALMOST_FULL   (af1)
`endif
  );

  function automatic logic [31:0] wa0();
    return {28'd0, ba_w0, row_w0, col_w0};
  endfunction

  function automatic logic [31:0] ra0();
    return {28'd0, ba_r0, row_r0, col_r0};
  endfunction

  function automatic logic [31:0] wa1();
    return {28'd0, ba_w1, row_w1, col_w1};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  // Apply one cycle of inputs, then sample 1 time unit after the rising edge.
  task automatic step(input logic wr, input logic rd, input logic clr);
    @(negedge CLK);
    WR_NEXT = wr;
    RD_NEXT = rd;
    CLEAR   = clr;
    @(posedge CLK);
    #1;
    WR_NEXT = 1'b0;
    RD_NEXT = 1'b0;
    CLEAR   = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_waddr"}, wa0(), 32'd0);
    chk({tag, "_raddr"}, ra0(), 32'd0);
    chk({tag, "_count"}, 32'(count0), 32'd0);
    chk({tag, "_empty"}, 32'(empty0), 32'd1);
    chk({tag, "_full"},  32'(full0), 32'd0);
    chk({tag, "_ovf"},   32'(ovf0), 32'd0);
    chk({tag, "_udf"},   32'(udf0), 32'd0);
  endtask

  logic [3:0] exp_ord0 [5];
  logic [3:0] exp_ord1 [5];

  initial begin
    exp_ord0 = '{4'b0010, 4'b0100, 4'b0110, 4'b0001, 4'b0011};
    exp_ord1 = '{4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101};

    RESET   = 1'b0;
    CLEAR   = 1'b0;
    WR_NEXT = 1'b0;
    RD_NEXT = 1'b0;
`ifdef SDRAM_ADDR_RING_WATERMARK_EN
    WM_LEVEL = 5'd4;
`endif
    #2;
    chk_reset_state("por");
    repeat (2) @(negedge CLK);
    RESET = 1'b1;

    // Field ordering for both layouts
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 1'b0, 1'b0);
      chk($sformatf("ord0_w%0d", k + 1), wa0(), 32'(exp_ord0[k]));
      chk($sformatf("ord1_w%0d", k + 1), wa1(), 32'(exp_ord1[k]));
    end
    chk("ord_count", 32'(count0), 32'd5);
    chk("ord_raddr", ra0(), 32'd0);

    // Asynchronous reset mid-cycle, checked before any further clock edge
    @(posedge CLK);
    #3;
    RESET = 1'b0;
    #1;
    chk_reset_state("async_rst");
    @(negedge CLK);
    RESET = 1'b1;

    // Fill to full, then overflow
    for (int k = 0; k < 16; k++) step(1'b1, 1'b0, 1'b0);
    chk("full_count", 32'(count0), 32'd16);
    chk("full_flag", 32'(full0), 32'd1);
    chk("full_empty", 32'(empty0), 32'd0);
    chk("full_ovf_pre", 32'(ovf0), 32'd0);
    step(1'b1, 1'b0, 1'b0);
    chk("ovf_waddr", wa0(), 32'd0);
    chk("ovf_count", 32'(count0), 32'd16);
    chk("ovf_flag", 32'(ovf0), 32'd1);
    // Write + read together while full: both advance
    step(1'b1, 1'b1, 1'b0);
    chk("fullrw_count", 32'(count0), 32'd16);
    chk("fullrw_full", 32'(full0), 32'd1);
    chk("fullrw_waddr", wa0(), 32'h2);
    chk("fullrw_raddr", ra0(), 32'h2);
    chk("fullrw_udf", 32'(udf0), 32'd0);

    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;

    // Underflow from reset, then write + read while empty
    step(1'b0, 1'b1, 1'b0);
    chk("udf_raddr", ra0(), 32'd0);
    chk("udf_count", 32'(count0), 32'd0);
    chk("udf_flag", 32'(udf0), 32'd1);
    step(1'b1, 1'b1, 1'b0);
    chk("emptyrw_count", 32'(count0), 32'd1);
    chk("emptyrw_raddr", ra0(), 32'd0);
    chk("emptyrw_waddr", wa0(), 32'h2);

    step(1'b0, 1'b0, 1'b1);
    chk_reset_state("clear");

    // Wrap-around with alternating write/read
    for (int i = 1; i <= 20; i++) begin
      step(1'b1, 1'b0, 1'b0);
      chk($sformatf("wrap_cnt_w%0d", i), 32'(count0), 32'd1);
      if (i == 16) chk("wrap_waddr16", wa0(), 32'd0);
      if (i == 17) chk("wrap_waddr17", wa0(), 32'h2);
      step(1'b0, 1'b1, 1'b0);
      chk($sformatf("wrap_cnt_r%0d", i), 32'(count0), 32'd0);
    end
    chk("wrap_ovf", 32'(ovf0), 32'd0);
    chk("wrap_udf", 32'(udf0), 32'd0);

    // CLEAR priority over WR_NEXT with OVF set and COUNT=7
    step(1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 17; k++) step(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 9; k++) step(1'b0, 1'b1, 1'b0);
    chk("pre_clr_count", 32'(count0), 32'd7);
    chk("pre_clr_ovf", 32'(ovf0), 32'd1);
    step(1'b1, 1'b0, 1'b1);
    chk("clrpri_count", 32'(count0), 32'd0);
    chk("clrpri_ovf", 32'(ovf0), 32'd0);
    chk("clrpri_waddr", wa0(), 32'd0);
    chk("clrpri_empty", 32'(empty0), 32'd1);

`ifdef SDRAM_ADDR_RING_WATERMARK_EN
    chk("wm_idle", 32'(af0), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      step(1'b1, 1'b0, 1'b0);
      chk($sformatf("wm_w%0d", k), 32'(af0), (k >= 4) ? 32'd1 : 32'd0);
    end
    step(1'b0, 1'b0, 1'b1);
    chk("wm_clear", 32'(af0), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_sdram_addr_ring_ctrl

// File: doc/sdram_addr_ring_ctrl.md
Name: sdram_addr_ring_ctrl

Overview:
Parametrised successor to the single write-address counter. Keeps independent write and read pointers over the SDRAM address space, so the SDRAM operates as one circular buffer. Each pointer is decoded into bank/row/column fields, with a selectable field order. Provides full/empty/occupancy status and sticky error flags. Sits between the sensor-data capture path (producer), the downlink/readback path (consumer) and the SDRAM command controller.

Parameters:
BA_W, 2, bank address width
ROW_W, 13, row address width
COL_W, 9, column address width
ORDER, 0, field order: 0 = row fastest, then column, then bank (legacy layout); 1 = column fastest, then row, then bank
(derived) ADDR_W = BA_W+ROW_W+COL_W; DEPTH = 2^ADDR_W

Ports:
CLK  in  1  system clock; all state changes on rising edge
RESET  in  1  asynchronous, active-low reset
CLEAR  in  1  synchronous clear of pointers and flags
WR_NEXT  in  1  one-cycle pulse: current write address consumed, advance
RD_NEXT  in  1  one-cycle pulse: current read address consumed, advance
BA_WRITE_OUT / ROW_WRITE_OUT / COL_WRITE_OUT  out  BA_W / ROW_W / COL_W  decoded write address
BA_READ_OUT / ROW_READ_OUT / COL_READ_OUT  out  BA_W / ROW_W / COL_W  decoded read address
COUNT  out  ADDR_W+1  occupancy, 0..DEPTH
FULL  out  1  COUNT == DEPTH
EMPTY  out  1  COUNT == 0
OVF  out  1  sticky: write attempted while full
UDF  out  1  sticky: read attempted while empty

Behaviour:
- Pointers wp and rp are each ADDR_W+1 bits; the MSB is the lap bit. COUNT = wp - rp, modulo 2^(ADDR_W+1).
- Address fields are decoded from ptr[ADDR_W-1:0] and are combinational from the pointer registers. A new address is valid in the cycle after the advancing edge, i.e. 1-cycle latency from the NEXT pulse.
- ORDER=0: row = ptr[ROW_W-1:0], col = next COL_W bits, bank = top BA_W bits.
- ORDER=1: col = ptr[COL_W-1:0], row = next ROW_W bits, bank = top BA_W bits.
- Reset (RESET low, asynchronous): wp=rp=0; all address outputs 0; COUNT=0; EMPTY=1; FULL=0; OVF=UDF=0.
- CLEAR high at a clock edge gives the same state as reset, and takes priority over WR_NEXT and RD_NEXT.
- Write accepted: WR_NEXT=1 and (not FULL, or RD_NEXT accepted in the same cycle). Then wp += 1.
- Read accepted: RD_NEXT=1 and not EMPTY. Then rp += 1.
- WR_NEXT while FULL with no RD_NEXT: write ignored, wp held, OVF set.
- RD_NEXT while EMPTY: read ignored, rp held, UDF set. If WR_NEXT is also high, the write is still accepted, giving COUNT=1.
- Simultaneous accepted write and read: both pointers advance and COUNT is unchanged. This applies when FULL too: the read frees a slot.
- Wrap-around: the address field goes from all-ones to 0 and the lap bit toggles. The boundary needs no special-casing.
- OVF and UDF stay set until RESET or CLEAR.
- RESET asserted mid-operation: every output returns to its reset value immediately, without waiting for a clock edge.
- NEXT inputs are synchronous level samples. Edge detection is the caller's job; a level held high advances once per cycle.

Optional Feature:
Macro SDRAM_ADDR_RING_WATERMARK_EN.
- Defined: adds input WM_LEVEL (ADDR_W+1 bits) and output ALMOST_FULL, a register updated every cycle to (next COUNT >= WM_LEVEL). ALMOST_FULL resets to 0 and is cleared by CLEAR.
- Not defined: neither port exists and there is no watermark logic.

Decomposition:
- Shared package sdram_addr_pkg: ORDER_ROW_FIRST=0 and ORDER_COL_FIRST=1 constants; default BA_W/ROW_W/COL_W matching the board SDRAM part.
- One sub-module, sdram_addr_decode: parametrised pointer-to-{bank,row,col} mapper. It is instantiated twice, once for the write pointer and once for the read pointer.

Test Plan:
All scenarios use BA_W=1, ROW_W=2, COL_W=1 (DEPTH=16).
- Reset: assert RESET low mid-cycle -> all addresses 0, COUNT=0, EMPTY=1, FULL=0, OVF=UDF=0, without a clock edge.
- Ordering: ORDER=0, 5 WR_NEXT pulses -> write (bank,row,col) after each = (0,1,0),(0,2,0),(0,3,0),(0,0,1),(0,1,1). ORDER=1, same stimulus -> (0,0,1),(0,1,0),(0,1,1),(0,2,0),(0,2,1).
- Full/overflow: 16 writes -> FULL=1, COUNT=16; 17th write -> wp unchanged, OVF=1. WR_NEXT+RD_NEXT together while full -> both advance, COUNT=16, FULL=1.
- Empty/underflow: RD_NEXT at reset -> rp=0, UDF=1. WR_NEXT+RD_NEXT together while empty -> write accepted, read ignored, COUNT=1.
- Wrap: 20 write/read pairs -> write address returns to (0,0,0) after 16, then (0,1,0); COUNT oscillates 1/0; no OVF/UDF.
- CLEAR priority: COUNT=7 with OVF=1, then CLEAR+WR_NEXT in the same cycle -> COUNT=0 and OVF=0. With the watermark enabled, WM_LEVEL=4 -> ALMOST_FULL=1 after the 4th write, 0 after CLEAR.
